// File: rtl/sha_core_scheduler.sv
// sha_core_scheduler
//   Runs a bank of NUM_CORES SHA-256 nonce cores over nonces 0..NONCE_COUNT-1,
//   one batch of NUM_CORES nonces at a time. It also shares one memory port
//   between the cores through a round-robin arbiter.
//
//   Ports:
//     clk, reset        clock, synchronous active-high reset
//     start / done      begin a run / run complete (held until next start)
//     core_start        one-cycle launch pulse per active core
//     core_nonce        nonce for core i at [32i+31:32i], stable per batch
//     core_done         per-core completion (level or pulse)
//     core_mem_*        per-core memory request (req, we, addr, wdata)
//     core_mem_gnt      one-hot combinational grant
//     core_rvalid       one-hot read-data-valid, two cycles after a read grant
//     core_rdata        memory read data broadcast to every core
//     mem_*             registered memory port; read data has 1-cycle latency
//
//   Optional: define SCHED_CYCLE_CNT_EN to add cycle_count[31:0]. It counts
//   LAUNCH/RUN cycles, is cleared on an accepted start and saturates.
module sha_core_scheduler #(
   parameter int NUM_CORES   = 8,
   parameter int NONCE_COUNT = 16,
   parameter int AW          = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   output logic                    done,
   output logic [NUM_CORES-1:0]    core_start,
   output logic [32*NUM_CORES-1:0] core_nonce,
   input  logic [NUM_CORES-1:0]    core_done,
   input  logic [NUM_CORES-1:0]    core_mem_req,
   input  logic [NUM_CORES-1:0]    core_mem_we,
   input  logic [AW*NUM_CORES-1:0] core_mem_addr,
   input  logic [32*NUM_CORES-1:0] core_mem_wdata,
   output logic [NUM_CORES-1:0]    core_mem_gnt,
   output logic [NUM_CORES-1:0]    core_rvalid,
   output logic [31:0]             core_rdata,
   output logic                    mem_we,
   output logic [AW-1:0]           mem_addr,
   output logic [31:0]             mem_write_data,
   input  logic [31:0]             mem_read_data
`ifdef SCHED_CYCLE_CNT_EN
   ,
   output logic [31:0]             cycle_count
`endif
);

   localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_FIN} state_t;

   state_t                  state_reg;
   logic [31:0]             base_reg;
   logic [NUM_CORES-1:0]    seen_reg;
   logic [PW-1:0]           rr_ptr_reg;
   logic                    done_reg;
   logic [NUM_CORES-1:0]    core_start_reg;
   logic [32*NUM_CORES-1:0] core_nonce_reg;
   logic                    mem_we_reg;
   logic [AW-1:0]           mem_addr_reg;
   logic [31:0]             mem_wdata_reg;
   logic                    rd_stage_reg;   // a read is on mem_addr this cycle
   logic [PW-1:0]           rd_core_reg;
   logic [NUM_CORES-1:0]    rvalid_reg;

   logic [NUM_CORES-1:0]    active;
   logic [NUM_CORES-1:0]    launch_active;
   logic [32*NUM_CORES-1:0] launch_nonce;
   logic [31:0]             launch_base;
   logic                    more_batches;
   logic                    batch_complete;

   // The next launch starts at 0 from IDLE/DONE and one batch further from RUN.
   assign launch_base    = (state_reg == S_RUN) ? (base_reg + 32'(NUM_CORES)) : 32'd0;
   assign more_batches   = ({1'b0, base_reg} + 33'(NUM_CORES)) < 33'(NONCE_COUNT);
   // Hold off while a read is on the memory port, so its rvalid is delivered first.
   assign batch_complete = (seen_reg == active) && !rd_stage_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CORES; gi++) begin : g_core
         assign active[gi]        = ({1'b0, base_reg} + 33'(gi)) < 33'(NONCE_COUNT);
         assign launch_active[gi] = ({1'b0, launch_base} + 33'(gi)) < 33'(NONCE_COUNT);
         assign launch_nonce[gi*32 +: 32] = launch_base + 32'(gi);
      end
   endgenerate

   // Round-robin arbiter: first eligible requester at or after rr_ptr.
   logic [NUM_CORES-1:0] req_ok;
   logic [NUM_CORES-1:0] gnt;
   logic                 gnt_any;
   logic [PW-1:0]        gnt_idx;
   logic [PW-1:0]        rr_next;
   int                   idx;

   always_comb begin
      req_ok  = core_mem_req & active & {NUM_CORES{state_reg == S_RUN}};
      gnt     = '0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      idx     = 0;
      for (int k = 0; k < NUM_CORES; k++) begin
         idx = (int'(rr_ptr_reg) + k) % NUM_CORES;
         if (!gnt_any && req_ok[idx]) begin
            gnt_any = 1'b1;
            gnt_idx = PW'(idx);
         end
      end
      if (gnt_any) gnt[gnt_idx] = 1'b1;
      rr_next = PW'((int'(gnt_idx) + 1) % NUM_CORES);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= S_IDLE;
         base_reg       <= '0;
         seen_reg       <= '0;
         rr_ptr_reg     <= '0;
         done_reg       <= 1'b0;
         core_start_reg <= '0;
         core_nonce_reg <= '0;
         mem_we_reg     <= 1'b0;
         mem_addr_reg   <= '0;
         mem_wdata_reg  <= '0;
         rd_stage_reg   <= 1'b0;
         rd_core_reg    <= '0;
         rvalid_reg     <= '0;
      end else begin
         core_start_reg <= '0;

         // Memory stage: the granted request appears on the port next cycle.
         if (gnt_any) begin
            mem_we_reg    <= core_mem_we[gnt_idx];
            mem_addr_reg  <= core_mem_addr[gnt_idx*AW +: AW];
            mem_wdata_reg <= core_mem_wdata[gnt_idx*32 +: 32];
            rd_stage_reg  <= !core_mem_we[gnt_idx];
            rd_core_reg   <= gnt_idx;
            rr_ptr_reg    <= rr_next;
         end else begin
            mem_we_reg   <= 1'b0;
            rd_stage_reg <= 1'b0;
         end

         rvalid_reg <= '0;
         if (rd_stage_reg) rvalid_reg[rd_core_reg] <= 1'b1;

         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  state_reg      <= S_LAUNCH;
                  base_reg       <= launch_base;
                  core_start_reg <= launch_active;
                  core_nonce_reg <= launch_nonce;
               end
            end
            S_LAUNCH: begin
               seen_reg  <= '0;
               state_reg <= S_RUN;
            end
            S_RUN: begin
               seen_reg <= seen_reg | (core_done & active);
               if (batch_complete) begin
                  if (more_batches) begin
                     state_reg      <= S_LAUNCH;
                     base_reg       <= launch_base;
                     core_start_reg <= launch_active;
                     core_nonce_reg <= launch_nonce;
                  end else begin
                     state_reg <= S_FIN;
                     done_reg  <= 1'b1;
                  end
               end
            end
            S_FIN: begin
               if (start) begin
                  state_reg      <= S_LAUNCH;
                  done_reg       <= 1'b0;
                  base_reg       <= launch_base;
                  core_start_reg <= launch_active;
                  core_nonce_reg <= launch_nonce;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

`ifdef SCHED_CYCLE_CNT_EN
   logic [31:0] cycle_cnt_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_cnt_reg <= '0;
      end else if ((state_reg == S_IDLE || state_reg == S_FIN) && start) begin
         cycle_cnt_reg <= '0;
      end else if ((state_reg == S_LAUNCH || state_reg == S_RUN) && cycle_cnt_reg != 32'hFFFF_FFFF) begin
         cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      end
   end

   assign cycle_count = cycle_cnt_reg;
`endif

   assign done           = done_reg;
   assign core_start     = core_start_reg;
   assign core_nonce     = core_nonce_reg;
   assign core_mem_gnt   = gnt;
   assign core_rvalid    = rvalid_reg;
   assign core_rdata     = mem_read_data;
   assign mem_we         = mem_we_reg;
   assign mem_addr       = mem_addr_reg;
   assign mem_write_data = mem_wdata_reg;

endmodule

// File: tb/tb_sha_core_scheduler.sv
// tb_sha_core_scheduler
//   Directed bench for sha_core_scheduler. Instance u_a runs 16 nonces
//   (two full batches of 8 cores). Instance u_b runs 10 nonces, so its
//   second batch is partial. A vector table covers the arbiter and memory
//   pipeline. Hand-written sequences cover batch completion, restart and reset.
module tb_sha_core_scheduler;

   localparam int N  = 8;
   localparam int AW = 16;

   logic clk = 1'b0;
   logic reset;
   logic start;

   always #5 clk = ~clk;

   // Instance A (NONCE_COUNT = 16)
   logic            done_a;
   logic [N-1:0]    core_start_a;
   logic [32*N-1:0] core_nonce_a;
   logic [N-1:0]    core_done_a;
   logic [N-1:0]    req_a;
   logic [N-1:0]    we_a;
   logic [AW*N-1:0] addr_a;
   logic [32*N-1:0] wdata_a;
   logic [N-1:0]    gnt_a;
   logic [N-1:0]    rvalid_a;
   logic [31:0]     rdata_a;
   logic            mem_we_a;
   logic [AW-1:0]   mem_addr_a;
   logic [31:0]     mem_wdata_a;
   logic [31:0]     mem_rdata;
`ifdef SCHED_CYCLE_CNT_EN
   logic [31:0]     cycle_count_a;
   logic [31:0]     cycle_count_b;
`endif

   // Instance B (NONCE_COUNT = 10), memory side idle
   logic            done_b;
   logic [N-1:0]    core_start_b;
   logic [32*N-1:0] core_nonce_b;
   logic [N-1:0]    core_done_b;
   logic [N-1:0]    zero_n;
   logic [AW*N-1:0] zero_addr;
   logic [32*N-1:0] zero_data;
   logic [N-1:0]    gnt_b;
   logic [N-1:0]    rvalid_b;
   logic [31:0]     rdata_b;
   logic            mem_we_b;
   logic [AW-1:0]   mem_addr_b;
   logic [31:0]     mem_wdata_b;

   sha_core_scheduler #(.NUM_CORES(N), .NONCE_COUNT(16), .AW(AW)) u_a (
      .clk(clk), .reset(reset), .start(start), .done(done_a),
      .core_start(core_start_a), .core_nonce(core_nonce_a), .core_done(core_done_a),
      .core_mem_req(req_a), .core_mem_we(we_a), .core_mem_addr(addr_a),
      .core_mem_wdata(wdata_a), .core_mem_gnt(gnt_a), .core_rvalid(rvalid_a),
      .core_rdata(rdata_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
      .mem_write_data(mem_wdata_a), .mem_read_data(mem_rdata)
`ifdef SCHED_CYCLE_CNT_EN
      , .cycle_count(cycle_count_a)
`endif
   );

   sha_core_scheduler #(.NUM_CORES(N), .NONCE_COUNT(10), .AW(AW)) u_b (
      .clk(clk), .reset(reset), .start(start), .done(done_b),
      .core_start(core_start_b), .core_nonce(core_nonce_b), .core_done(core_done_b),
      .core_mem_req(zero_n), .core_mem_we(zero_n), .core_mem_addr(zero_addr),
      .core_mem_wdata(zero_data), .core_mem_gnt(gnt_b), .core_rvalid(rvalid_b),
      .core_rdata(rdata_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
      .mem_write_data(mem_wdata_b), .mem_read_data(mem_rdata)
`ifdef SCHED_CYCLE_CNT_EN
      , .cycle_count(cycle_count_b)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One row per cycle of the arbitration/memory sequence. The exp_m_* and
   // exp_rvalid fields are the registered outputs seen during that cycle.
   typedef struct {
      logic [7:0]  req;
      logic [7:0]  we;
      logic [31:0] rd;
      logic [7:0]  exp_gnt;
      logic        exp_m_we;
      logic [15:0] exp_m_addr;
      logic [31:0] exp_m_wdata;
      logic [7:0]  exp_rvalid;
   } vec_t;

   vec_t vecs [8];

   initial begin
      // Core i uses address 0x0010+i and write data 0xA000_0000+i.
      for (int i = 0; i < N; i++) begin
         addr_a[i*AW +: AW]  = 16'h0010 + 16'(i);
         wdata_a[i*32 +: 32] = 32'hA000_0000 + 32'(i);
      end
      zero_n = '0; zero_addr = '0; zero_data = '0;
      req_a = '0; we_a = '0; core_done_a = '0; core_done_b = '0;
      mem_rdata = '0; start = 1'b0; reset = 1'b1;

      // rr_ptr starts at 0. The lone grant to core 4 moves it to 5. Then
      // {1,4,6} are granted in the order 6, 1, 4. The read by core 2 follows.
      vecs[0] = '{8'h10, 8'h10, 32'h0,         8'h10, 1'b0, 16'h0000, 32'h0,         8'h00};
      vecs[1] = '{8'h52, 8'h52, 32'h0,         8'h40, 1'b1, 16'h0014, 32'hA000_0004, 8'h00};
      vecs[2] = '{8'h12, 8'h12, 32'h0,         8'h02, 1'b1, 16'h0016, 32'hA000_0006, 8'h00};
      vecs[3] = '{8'h10, 8'h10, 32'h0,         8'h10, 1'b1, 16'h0011, 32'hA000_0001, 8'h00};
      vecs[4] = '{8'h04, 8'h00, 32'h0,         8'h04, 1'b1, 16'h0014, 32'hA000_0004, 8'h00};
      vecs[5] = '{8'h00, 8'h00, 32'h0,         8'h00, 1'b0, 16'h0012, 32'hA000_0002, 8'h00};
      vecs[6] = '{8'h00, 8'h00, 32'hDEADBEEF,  8'h00, 1'b0, 16'h0012, 32'hA000_0002, 8'h04};
      vecs[7] = '{8'h00, 8'h00, 32'h0,         8'h00, 1'b0, 16'h0012, 32'hA000_0002, 8'h00};

      // ---- reset state
      tick(); tick();
      reset = 1'b0;
      check("rst_done",       64'(done_a),       64'h0);
      check("rst_core_start", 64'(core_start_a), 64'h0);
      check("rst_gnt",        64'(gnt_a),        64'h0);
      check("rst_rvalid",     64'(rvalid_a),     64'h0);
      check("rst_mem_we",     64'(mem_we_a),     64'h0);
      check("rst_mem_addr",   64'(mem_addr_a),   64'h0);
      check("rst_nonce3",     64'(core_nonce_a[3*32 +: 32]), 64'h0);
      tick();

      // ---- start -> LAUNCH one cycle later
      start = 1'b1;
      tick();
      start = 1'b0;
      check("launch1_start_a", 64'(core_start_a), 64'hFF);
      check("launch1_nonce3",  64'(core_nonce_a[3*32 +: 32]), 64'd3);
      check("launch1_start_b", 64'(core_start_b), 64'hFF);
      tick();
      check("run1_start_low",  64'(core_start_a), 64'h0);

      // ---- arbitration and memory pipeline table
      for (int v = 0; v < 8; v++) begin
         req_a = vecs[v].req;
         we_a = vecs[v].we;
         mem_rdata = vecs[v].rd;
         #1;
         check($sformatf("vec%0d_gnt", v),    64'(gnt_a),       64'(vecs[v].exp_gnt));
         check($sformatf("vec%0d_mem_we", v), 64'(mem_we_a),    64'(vecs[v].exp_m_we));
         check($sformatf("vec%0d_addr", v),   64'(mem_addr_a),  64'(vecs[v].exp_m_addr));
         check($sformatf("vec%0d_wdata", v),  64'(mem_wdata_a), 64'(vecs[v].exp_m_wdata));
         check($sformatf("vec%0d_rvalid", v), 64'(rvalid_a),    64'(vecs[v].exp_rvalid));
         check($sformatf("vec%0d_rdata", v),  64'(rdata_a),     64'(vecs[v].rd));
         $display("vector %0d: req=%02h gnt=%02h mem_addr=%04h mem_we=%0d rvalid=%02h",
                  v, req_a, gnt_a, mem_addr_a, mem_we_a, rvalid_a);
         tick();
      end
      req_a = '0; we_a = '0; mem_rdata = '0;

      // ---- batch 1 completion; a repeated core_done does not count twice
      core_done_a = 8'h0F; core_done_b = 8'h0F;
      tick();
      tick();
      core_done_a = '0; core_done_b = '0;
      tick(); tick();
      check("no_early_launch_a", 64'(core_start_a), 64'h0);
      check("no_early_launch_b", 64'(core_start_b), 64'h0);
      core_done_a = 8'hF0; core_done_b = 8'hF0;
      tick();
      core_done_a = '0; core_done_b = '0;
      check("launch2_not_yet", 64'(core_start_a), 64'h0);
      tick();
      check("launch2_start_a", 64'(core_start_a), 64'hFF);
      check("launch2_nonce3",  64'(core_nonce_a[3*32 +: 32]), 64'd11);
      check("launch2_start_b", 64'(core_start_b), 64'h03);
      check("launch2_b_nonce0", 64'(core_nonce_b[0 +: 32]),  64'd8);
      check("launch2_b_nonce1", 64'(core_nonce_b[32 +: 32]), 64'd9);
      $display("batch 2 launched: a=%02h b=%02h", core_start_a, core_start_b);
      tick();

      // ---- start in RUN ignored; stray done on inactive core of B ignored
      start = 1'b1;
      tick();
      start = 1'b0;
      check("run_start_ignored", 64'(core_start_a), 64'h0);
      check("run_start_no_done", 64'(done_a), 64'h0);
      core_done_a = 8'hFF; core_done_b = 8'h20;
      tick();
      core_done_a = '0; core_done_b = '0;
      check("done_a_lat1", 64'(done_a), 64'h0);
      tick();
      check("done_a_lat2", 64'(done_a), 64'h1);
      tick();
      check("b_stray_ignored", 64'(done_b), 64'h0);
      core_done_b = 8'h03;
      tick();
      core_done_b = '0;
      check("done_b_lat1", 64'(done_b), 64'h0);
      tick();
      check("done_b_lat2", 64'(done_b), 64'h1);
      check("done_a_held", 64'(done_a), 64'h1);
      $display("run complete: done_a=%0d done_b=%0d", done_a, done_b);

      // ---- restart from DONE
      start = 1'b1;
      tick();
      start = 1'b0;
      check("restart_done_low", 64'(done_a), 64'h0);
      check("restart_start",    64'(core_start_a), 64'hFF);
      check("restart_nonce3",   64'(core_nonce_a[3*32 +: 32]), 64'd3);
      tick();

      // ---- a read in flight delays completion by one cycle
      req_a = 8'h01; we_a = 8'h00; core_done_a = 8'hFF;
      #1;
      check("rd_delay_gnt", 64'(gnt_a), 64'h01);
      tick();
      req_a = '0; core_done_a = '0;
      tick();
      check("rd_delay_rvalid", 64'(rvalid_a), 64'h01);
      check("rd_delay_no_launch", 64'(core_start_a), 64'h0);
      tick();
      check("rd_delay_launch", 64'(core_start_a), 64'hFF);
      tick();
      core_done_a = 8'hFF;
      tick();
      core_done_a = '0;
      tick(); tick();
      check("rd_run_done", 64'(done_a), 64'h1);

      // ---- reset in the middle of a run
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      req_a = 8'h01; we_a = 8'h01;
      tick();
      check("pre_rst_mem_we", 64'(mem_we_a), 64'h1);
      reset = 1'b1;
      tick();
      check("mid_rst_gnt",        64'(gnt_a),        64'h0);
      check("mid_rst_mem_we",     64'(mem_we_a),     64'h0);
      check("mid_rst_rvalid",     64'(rvalid_a),     64'h0);
      check("mid_rst_core_start", 64'(core_start_a), 64'h0);
      check("mid_rst_nonce3",     64'(core_nonce_a[3*32 +: 32]), 64'h0);
      reset = 1'b0; req_a = '0; we_a = '0;
      tick(); tick();
      check("idle_stays", 64'(core_start_a), 64'h0);
      check("idle_no_done", 64'(done_a), 64'h0);
      $display("reset mid-run handled");

      // ---- short run from IDLE: 6 LAUNCH/RUN cycles in total
      start = 1'b1;
      tick();
      start = 1'b0;
      check("idle_launch", 64'(core_start_a), 64'hFF);
      tick();
      core_done_a = 8'hFF;
      tick();
      core_done_a = '0;
      tick();
      check("short_launch2", 64'(core_start_a), 64'hFF);
      tick();
      core_done_a = 8'hFF;
      tick();
      core_done_a = '0;
      tick();
      check("short_done", 64'(done_a), 64'h1);
`ifdef SCHED_CYCLE_CNT_EN
      check("cycle_count", 64'(cycle_count_a), 64'd6);
      tick(); tick();
      check("cycle_count_frozen", 64'(cycle_count_a), 64'd6);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/sha_core_scheduler.md
Name: sha_core_scheduler

Overview:
- Sequences a bank of NUM_CORES parallel SHA-256 nonce cores across a nonce range of NONCE_COUNT values, dispatched in batches.
- Shares the single testbench memory port between the cores with a round-robin arbiter.
- Raises done once every nonce's hash has been computed and written.
- Sits between the top-level bitcoin_hash wrapper and the core instances.

Parameters:
- NUM_CORES, 8, number of core instances; power of two, 1..16.
- NONCE_COUNT, 16, total nonces 0..NONCE_COUNT-1; must be >= 1.
- AW, 16, memory address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE or DONE
- done  out  1  run complete; held high until next accepted start
- core_start  out  NUM_CORES  one-cycle launch pulse per core
- core_nonce  out  32*NUM_CORES  nonce for core i at bits [32i+31:32i]
- core_done  in  NUM_CORES  core finished; level or pulse
- core_mem_req  in  NUM_CORES  core requests a memory access
- core_mem_we  in  NUM_CORES  write flag per request
- core_mem_addr  in  AW*NUM_CORES  address per core
- core_mem_wdata  in  32*NUM_CORES  write data per core
- core_mem_gnt  out  NUM_CORES  one-hot grant, combinational, same cycle as req
- core_rvalid  out  NUM_CORES  one-hot; read data valid for that core
- core_rdata  out  32  mem_read_data broadcast to all cores
- mem_we  out  1  memory write enable, registered
- mem_addr  out  AW  memory address, registered
- mem_write_data  out  32  memory write data, registered
- mem_read_data  in  32  memory read data; 1-cycle latency after mem_addr

Behaviour:
- Reset values: all outputs 0; state=IDLE; base=0; rr_ptr=0; seen mask=0.
- State IDLE: start=1 -> LAUNCH with base=0.
- State LAUNCH (1 cycle):
  - core_start[i]=1 for each active core, i.e. base+i < NONCE_COUNT.
  - core_nonce[i]=base+i, held stable until the next LAUNCH.
  - seen mask cleared; -> RUN.
- State RUN:
  - seen |= core_done & active.
  - When seen==active AND no read is in flight (no rvalid due next cycle): if base+NUM_CORES < NONCE_COUNT, then base += NUM_CORES and go to LAUNCH; otherwise go to DONE.
- State DONE: done=1.
  - start=1 -> clear done and go to LAUNCH with base=0 (done falls the cycle LAUNCH is entered).
  - start is ignored in LAUNCH and RUN.
- Arbiter (RUN only; in all other states gnt=0 and mem_we=0):
  - Grant the first requester at or after rr_ptr, wrapping modulo NUM_CORES.
  - At most one grant per cycle.
  - On a grant to core g, rr_ptr <= g+1 (mod NUM_CORES); with no grant, rr_ptr holds.
- Memory timing:
  - Grant at cycle t -> mem_addr/mem_we/mem_write_data driven from core g's request at t+1.
  - If the request was a read, core_rvalid[g]=1 at t+2.
  - mem_we is deasserted at t+2 unless another write is granted.
- Back-to-back grants are allowed every cycle; reads and writes may interleave.
- Non-granted requesters hold req; no request is dropped.
- Partial final batch: inactive cores get neither start nor grant, and their core_done is masked.
- core_done from a core already in seen is ignored (no double count).
- Reset mid-run: within one cycle all core_start, gnt, rvalid and mem_we are 0; state=IDLE.
- Latency: start -> first core_start = 1 cycle; last core_done of the final batch -> done = 2 cycles (3 if a read completes that cycle).

Optional Feature:
- Macro: SCHED_CYCLE_CNT_EN.
- Defined:
  - Adds output cycle_count [31:0], cleared on an accepted start.
  - Increments each cycle in LAUNCH/RUN, frozen in DONE.
  - Saturates at 32'hFFFF_FFFF; reset value 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Launch: NUM_CORES=8, NONCE_COUNT=16, start pulse.
  - core_start=8'hFF one cycle later, core_nonce[3]=3.
  - After all 8 done: second LAUNCH with core_nonce[3]=11.
  - After those 8 done: done=1 two cycles later.
- Partial batch: NONCE_COUNT=10.
  - Second launch core_start=8'h03 with nonces 8 and 9.
  - Stray core_done[5] does not affect completion.
- Arbitration: cores 1, 4, 6 assert req simultaneously with rr_ptr=5.
  - Grants in order 6, 1, 4 on consecutive cycles.
  - mem_addr follows each grant one cycle later.
- Read: core 2 reads address 16'h0012 while memory returns 32'hDEADBEEF.
  - core_rvalid=8'h04 with core_rdata=32'hDEADBEEF two cycles after the grant.
- Reset and restart:
  - reset asserted in RUN -> next cycle all outputs 0 and state IDLE.
  - start while in RUN ignored; start in DONE restarts at base=0 and clears done.
- With SCHED_CYCLE_CNT_EN defined: cycle_count equals the exact LAUNCH+RUN cycle total and stays frozen after done.
